// File: rtl/fir_load_ctrl_if.sv
// Host-side bus for fir_load_ctrl: coefficient configuration port plus the
// valid/ready sample stream feeding the FIR.
interface fir_load_ctrl_if #(
  parameter int W1 = 8,
  parameter int AW = 2
);
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [W1-1:0] cfg_data;
  logic                 cfg_commit;
  logic                 cfg_busy;
  logic                 s_valid;
  logic signed [W1-1:0] s_data;
  logic                 s_ready;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_commit, s_valid, s_data,
    input  cfg_busy, s_ready
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_commit, s_valid, s_data,
    output cfg_busy, s_ready
  );
endinterface

// File: rtl/fir_load_ctrl.sv
// Coefficient-load sequencer for a transposed-form FIR: shadow bank, serial
// coefficient shift, pipeline flush, sample throttling and output-valid tracking.
module fir_load_ctrl #(
  parameter int W1 = 8,
  parameter int L  = 3,
  parameter int AW = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fir_load_ctrl_if.slave       bus,
  output logic                 fir_load_x,
  output logic signed [W1-1:0] fir_x,
  output logic signed [W1-1:0] fir_c,
  output logic                 y_valid,
  output logic                 err_underrun,
  output logic                 err_cfg,
  input  logic                 err_clr
);
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FLUSH} state_t;

  state_t               state_reg;
  logic [CW-1:0]        k_reg;
  logic [CW-1:0]        flush_cnt_reg;
  logic                 load_x_reg;
  logic signed [W1-1:0] x_reg;
  logic signed [W1-1:0] c_reg;
  logic [2:0]           accept_dly_reg;
  logic                 err_underrun_reg;
  logic                 err_cfg_reg;

  logic [L*W1-1:0]      shadow_flat;
  logic signed [W1-1:0] shadow_sel;
  logic                 run;
  logic                 accept;
  logic                 addr_ok;
  logic                 write_ok;

  assign run         = (state_reg == ST_RUN);
  assign bus.s_ready  = run;
  assign bus.cfg_busy = !run;
  assign accept      = bus.s_valid && run;
  assign write_ok    = bus.cfg_we && run && addr_ok;

  always_comb begin
    addr_ok    = 1'b0;
    shadow_sel = '0;
    for (int i = 0; i < L; i++) begin
      if (bus.cfg_addr == AW'(i)) addr_ok = 1'b1;
      if (k_reg == CW'(i)) shadow_sel = shadow_flat[i*W1 +: W1];
    end
  end

  // One register per shadow entry; only legal RUN-time writes land here.
  for (genvar gi = 0; gi < L; gi++) begin : g_shadow
    logic signed [W1-1:0] coef_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        coef_reg <= '0;
      end else if (write_ok && bus.cfg_addr == AW'(gi)) begin
        coef_reg <= bus.cfg_data;
      end
    end

    assign shadow_flat[gi*W1 +: W1] = coef_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_RUN;
      k_reg         <= '0;
      flush_cnt_reg <= '0;
      load_x_reg    <= 1'b1;
      x_reg         <= '0;
      c_reg         <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          load_x_reg <= 1'b1;
          x_reg      <= bus.s_valid ? bus.s_data : '0;
          if (bus.cfg_commit) begin
            state_reg <= ST_LOAD;
            k_reg     <= '0;
          end
        end
        ST_LOAD: begin
          // shadow[0] goes out first so it settles in the filter's c[0]
          load_x_reg <= 1'b0;
          x_reg      <= '0;
          c_reg      <= shadow_sel;
          if (k_reg == CW'(L - 1)) begin
            state_reg     <= ST_FLUSH;
            k_reg         <= '0;
            flush_cnt_reg <= '0;
          end else begin
            k_reg <= k_reg + CW'(1);
          end
        end
        ST_FLUSH: begin
          // L+1 zero samples clear x and every adder stage of the filter
          load_x_reg <= 1'b1;
          x_reg      <= '0;
          if (flush_cnt_reg == CW'(L)) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= ST_RUN;
        end
      endcase
    end
  end

  // Accepted sample reaches a[0] three edges after acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accept_dly_reg   <= '0;
      err_underrun_reg <= 1'b0;
      err_cfg_reg      <= 1'b0;
    end else begin
      accept_dly_reg <= {accept_dly_reg[1:0], accept};
      if (err_clr) begin
        err_underrun_reg <= 1'b0;
        err_cfg_reg      <= 1'b0;
      end else begin
        if (run && !bus.s_valid) err_underrun_reg <= 1'b1;
        if (bus.cfg_we && !(run && addr_ok)) err_cfg_reg <= 1'b1;
      end
    end
  end

  assign fir_load_x   = load_x_reg;
  assign fir_x        = x_reg;
  assign fir_c        = c_reg;
  assign y_valid      = accept_dly_reg[2];
  assign err_underrun = err_underrun_reg;
  assign err_cfg      = err_cfg_reg;
endmodule

// File: tb/tb_fir_load_ctrl.sv
// Self-checking bench for fir_load_ctrl: directed scenarios plus random traffic
// compared against a schedule-based reference model.
module tb_fir_load_ctrl;
  localparam int W1 = 8;
  localparam int L  = 3;
  localparam int AW = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 fir_load_x;
  logic signed [W1-1:0] fir_x;
  logic signed [W1-1:0] fir_c;
  logic                 y_valid;
  logic                 err_underrun;
  logic                 err_cfg;
  logic                 err_clr;

  fir_load_ctrl_if #(.W1(W1), .AW(AW)) bus ();

  fir_load_ctrl #(.W1(W1), .L(L), .AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .fir_load_x   (fir_load_x),
    .fir_x        (fir_x),
    .fir_c        (fir_c),
    .y_valid      (y_valid),
    .err_underrun (err_underrun),
    .err_cfg      (err_cfg),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a commit turns into a schedule of L coefficient shifts
  // followed by L+1 flush slots; RUN is simply "schedule empty".
  typedef struct {
    bit          lx;
    logic [W1-1:0] c;
  } step_t;

  step_t         plan[$];
  bit            acc_q[$];
  logic [W1-1:0] m_shadow [L];
  bit            m_lx, m_yv, m_eu, m_ec;
  logic [W1-1:0] m_x, m_c;
  bit            exp_ready, exp_busy;
  logic          obs_ready, obs_busy;
  logic [21:0]   obs_vec, exp_vec;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic model_reset();
    plan.delete();
    acc_q.delete();
    repeat (3) acc_q.push_back(1'b0);
    for (int i = 0; i < L; i++) m_shadow[i] = '0;
    m_lx = 1'b1; m_x = '0; m_c = '0; m_yv = 1'b0; m_eu = 1'b0; m_ec = 1'b0;
  endtask

  task automatic cycle(input bit sv, input logic [W1-1:0] sd, input bit we,
                       input logic [AW-1:0] addr, input logic [W1-1:0] data,
                       input bit cm, input bit clr);
    bit    run_now;
    step_t it;
    bus.s_valid = sv; bus.s_data = sd; bus.cfg_we = we; bus.cfg_addr = addr;
    bus.cfg_data = data; bus.cfg_commit = cm; err_clr = clr;
    #1;
    run_now   = (plan.size() == 0);
    obs_ready = bus.s_ready;
    obs_busy  = bus.cfg_busy;
    exp_ready = run_now;
    exp_busy  = !run_now;
    if (clr) begin
      m_eu = 1'b0; m_ec = 1'b0;
    end else begin
      if (run_now && !sv) m_eu = 1'b1;
      if (we && (!run_now || int'(addr) >= L)) m_ec = 1'b1;
    end
    if (we) $display("cfg write addr=%0d data=%0d %s", addr, data,
                     (run_now && int'(addr) < L) ? "stored" : "dropped");
    if (we && run_now && int'(addr) < L) m_shadow[int'(addr)] = data;
    if (run_now) begin
      m_lx = 1'b1;
      m_x  = sv ? sd : '0;
      if (cm) begin
        $display("cfg commit bank=%0d,%0d,%0d", m_shadow[0], m_shadow[1], m_shadow[2]);
        for (int k = 0; k < L; k++) plan.push_back('{lx: 1'b0, c: m_shadow[k]});
        for (int k = 0; k <= L; k++) plan.push_back('{lx: 1'b1, c: m_shadow[L-1]});
      end
    end else begin
      it   = plan.pop_front();
      m_lx = it.lx;
      m_x  = '0;
      m_c  = it.c;
    end
    acc_q.push_back(run_now && sv);
    void'(acc_q.pop_front());
    m_yv = acc_q[0];
    @(posedge clk);
    #1;
    obs_vec = {fir_load_x, fir_x, fir_c, y_valid, obs_ready, obs_busy, err_underrun, err_cfg};
    exp_vec = {m_lx, m_x, m_c, m_yv, exp_ready, exp_busy, m_eu, m_ec};
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 8'h7f; bus.cfg_we = 1'b0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.cfg_commit = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({fir_load_x, fir_x, fir_c, y_valid, err_underrun, err_cfg} !== {1'b1, 8'h00, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b_%h_%h_%b%b%b want=1_00_00_000", fir_load_x, fir_x, fir_c,
               y_valid, err_underrun, err_cfg);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.s_ready, bus.cfg_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release ready/busy got=%b%b want=10", bus.s_ready, bus.cfg_busy);
    end
  endtask

  task automatic test_load();
    logic [W1-1:0] cseq[$];
    int busy_cnt = 0;
    int low_cnt = 0;
    for (int a = 0; a < L; a++) begin
      cycle(1'b1, W1'($urandom), 1'b1, AW'(a), W1'(a + 1), 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL load_write%0d got=%h want=%h", a, obs_vec, exp_vec); end
    end
    cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL load_commit got=%h want=%h", obs_vec, exp_vec); end
    for (int i = 0; i < 2*L + 1; i++) begin
      cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL load_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
      if (obs_busy === 1'b1) busy_cnt++;
      if (fir_load_x === 1'b0) begin low_cnt++; cseq.push_back(fir_c); end
    end
    n_cmp++;
    if (busy_cnt != 2*L + 1) begin n_fail++; $display("FAIL load_busy_len got=%0d want=%0d", busy_cnt, 2*L + 1); end
    n_cmp++;
    if (low_cnt != L) begin n_fail++; $display("FAIL load_lx_low_len got=%0d want=%0d", low_cnt, L); end
    for (int k = 0; k < cseq.size(); k++) begin
      n_cmp++;
      if (cseq[k] !== W1'(k + 1)) begin n_fail++; $display("FAIL load_coef%0d got=%0d want=%0d", k, cseq[k], k + 1); end
    end
  endtask

  task automatic test_impulse();
    int first_rise = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, (i == 0) ? W1'(1) : W1'(0), 1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL impulse_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
      if (y_valid === 1'b1 && first_rise < 0) first_rise = i;
    end
    n_cmp++;
    if (first_rise != 2) begin n_fail++; $display("FAIL impulse_yvalid_delay got=%0d want=2", first_rise); end
  endtask

  task automatic test_underrun();
    bit pat [6] = '{1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      cycle(pat[i], W1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL underrun_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
    end
    n_cmp++;
    if (err_underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky got=%b want=1", err_underrun); end
    cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (err_underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr_priority got=%b want=0", err_underrun); end
  endtask

  task automatic test_cfg_errors();
    logic [W1-1:0] cseq[$];
    cycle(1'b1, W1'($urandom), 1'b1, 2'd3, 8'h99, 1'b0, 1'b1);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL cfgerr_badaddr got=%h want=%h", obs_vec, exp_vec); end
    cycle(1'b1, W1'($urandom), 1'b1, 2'd3, 8'h99, 1'b0, 1'b0);
    n_cmp++;
    if (err_cfg !== 1'b1) begin n_fail++; $display("FAIL cfgerr_badaddr_flag got=%b want=1", err_cfg); end
    cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2*L + 1; i++) begin
      cycle(1'b1, W1'($urandom), i == 0, '0, 8'h44, i == L + 1, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL cfgerr_busy_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
    end
    n_cmp++;
    if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL cfgerr_flush_commit_ignored busy got=%b want=0", bus.cfg_busy); end
    cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2*L + 1; i++) begin
      cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL cfgerr_recommit_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
      if (fir_load_x === 1'b0) cseq.push_back(fir_c);
    end
    n_cmp++;
    if (cseq.size() != L) begin n_fail++; $display("FAIL cfgerr_recommit_len got=%0d want=%0d", cseq.size(), L); end
    for (int k = 0; k < cseq.size(); k++) begin
      n_cmp++;
      if (cseq[k] !== W1'(k + 1)) begin n_fail++; $display("FAIL cfgerr_recommit_coef%0d got=%0d want=%0d", k, cseq[k], k + 1); end
    end
  endtask

  task automatic test_commit_with_write();
    logic [W1-1:0] cseq[$];
    cycle(1'b1, W1'($urandom), 1'b1, 2'd1, 8'ha5, 1'b1, 1'b1);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wrcommit_cyc got=%h want=%h", obs_vec, exp_vec); end
    for (int i = 0; i < 2*L + 1; i++) begin
      cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL wrcommit_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
      if (fir_load_x === 1'b0) cseq.push_back(fir_c);
    end
    n_cmp++;
    if (cseq.size() < 2 || cseq[1] !== 8'ha5) begin
      n_fail++;
      $display("FAIL wrcommit_coef1 got=%0d want=%0d", (cseq.size() < 2) ? 0 : cseq[1], 8'ha5);
    end
  endtask

  task automatic test_abort();
    logic [W1-1:0] cseq[$];
    cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL abort_load0 got=%h want=%h", obs_vec, exp_vec); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cfg_busy, fir_load_x, fir_c} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL abort_immediate got=%b_%b_%h want=0_1_00", bus.cfg_busy, fir_load_x, fir_c);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 2*L + 1; i++) begin
      cycle(1'b1, W1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL abort_recommit_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
      if (fir_load_x === 1'b0) cseq.push_back(fir_c);
    end
    n_cmp++;
    if (cseq.size() != L) begin n_fail++; $display("FAIL abort_recommit_len got=%0d want=%0d", cseq.size(), L); end
    for (int k = 0; k < cseq.size(); k++) begin
      n_cmp++;
      if (cseq[k] !== '0) begin n_fail++; $display("FAIL abort_coef%0d got=%0d want=0", k, cseq[k]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) != 0, W1'($urandom), $urandom_range(0, 3) == 0,
            AW'($urandom_range(0, 3)), W1'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 15) == 0);
      n_cmp++;
      if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random_cyc%0d got=%h want=%h", i, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_impulse();
    test_underrun();
    test_cfg_errors();
    test_commit_with_write();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
